// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: state encoding and counter sizing shared by the scan test controller.
package scan_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;
  function automatic int cnt_width(input int chain_len, input int capture_cycles);
    return $clog2((chain_len > capture_cycles ? chain_len : capture_cycles) + 1);
  endfunction
endpackage

// File: rtl/scan_shreg.sv
// scan_shreg: shift register with parallel load, serial in at LSB and serial out from MSB.
module scan_shreg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         sout
);
  logic [W:0] cat;
  assign cat  = {q, sin};
  assign sout = q[W-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= cat[W-1:0];
endmodule

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: scan test initiator running shift-in, capture, shift-out and masked compare.
module scan_test_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int   CHAIN_LEN      = 4,
  parameter int   CAPTURE_CYCLES = 1,
  parameter logic FILL_BIT       = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  output logic                 SE,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response
);
  localparam int CW = cnt_width(CHAIN_LEN, CAPTURE_CYCLES);
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CHAIN_LEN-1:0] exp_l, mask_l, pat_unused;
  logic                 pass_en, accept, pat_msb, rsp_unused, last_sh, last_cap;
  assign accept   = state == IDLE && start;
  assign last_sh  = cnt == CW'(CHAIN_LEN - 1);
  assign last_cap = cnt == CW'(CAPTURE_CYCLES - 1);
  scan_shreg #(.W(CHAIN_LEN)) u_pat (
    .clk(clk), .reset(reset), .load(accept), .shift(state == SHIFT_IN),
    .d(pattern), .sin(1'b0), .q(pat_unused), .sout(pat_msb)
  );
  // Response register is cleared on accept and holds its captured value until the next test.
  scan_shreg #(.W(CHAIN_LEN)) u_rsp (
    .clk(clk), .reset(reset), .load(accept), .shift(state == SHIFT_OUT),
    .d({CHAIN_LEN{1'b0}}), .sin(scan_out), .q(response), .sout(rsp_unused)
  );
  assign SE      = state == SHIFT_IN || state == SHIFT_OUT;
  assign scan_in = state == SHIFT_IN ? pat_msb : state == SHIFT_OUT ? FILL_BIT : 1'b0;
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign pass    = pass_en && ((response ^ exp_l) & mask_l) == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      exp_l   <= '0;
      mask_l  <= '0;
      pass_en <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state   <= SHIFT_IN;
          cnt     <= '0;
          exp_l   <= expected;
          mask_l  <= mask;
          pass_en <= 1'b0;
        end
        SHIFT_IN: begin
          cnt <= last_sh ? '0 : cnt + CW'(1);
          if (last_sh) state <= CAPTURE;
        end
        CAPTURE: begin
          cnt <= last_cap ? '0 : cnt + CW'(1);
          if (last_cap) state <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          cnt <= last_sh ? '0 : cnt + CW'(1);
          if (last_sh) begin
            state   <= DONE;
            pass_en <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb_scan_test_ctrl: drives the controller against a 4-bit scan counter and a 1-flop toggle chain.
module tb_scan_test_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       reset;
  logic       start_a, se_a, si_a, so_a, busy_a, done_a, pass_a;
  logic [3:0] pattern_a, expected_a, mask_a, response_a;
  logic       start_b, se_b, si_b, so_b, busy_b, done_b, pass_b;
  logic [0:0] pattern_b, expected_b, mask_b, response_b;
  logic [3:0] chain_a = 4'd0;
  logic       chain_b = 1'b0;
  int checks = 0, errors = 0;

  scan_test_ctrl #(.CHAIN_LEN(4), .CAPTURE_CYCLES(1), .FILL_BIT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pattern(pattern_a), .expected(expected_a),
    .mask(mask_a), .SE(se_a), .scan_in(si_a), .scan_out(so_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .response(response_a)
  );
  scan_test_ctrl #(.CHAIN_LEN(1), .CAPTURE_CYCLES(3), .FILL_BIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pattern(pattern_b), .expected(expected_b),
    .mask(mask_b), .SE(se_b), .scan_in(si_b), .scan_out(so_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .response(response_b)
  );

  // Scan-inserted targets: a 4-bit up counter and a single toggle flop.
  always @(posedge clk) chain_a <= se_a ? {chain_a[2:0], si_a} : chain_a + 4'd1;
  always @(posedge clk) chain_b <= se_b ? si_b : ~chain_b;
  assign so_a = chain_a[3];
  assign so_b = chain_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] se_model(input int n, input int c);
    logic [31:0] t = '0;
    for (int k = 1; k <= 2 * n + c; k++) t[k] = (k <= n) || (k > n + c);
    return t;
  endfunction

  task automatic run_a(input logic [3:0] pat, input logic [3:0] ex, input logic [3:0] msk,
                       input bit disturb, input bit do_reset,
                       output logic [3:0] rsp, output logic ps, output int lat,
                       output logic [31:0] se_tr, output bit busy_ok);
    se_tr = '0; lat = 0; busy_ok = 1; rsp = '0; ps = 1'b0;
    @(negedge clk);
    pattern_a = pat; expected_a = ex; mask_a = msk; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      se_tr[k] = se_a;
      if (done_a) begin
        lat = k; rsp = response_a; ps = pass_a;
        break;
      end
      if (!busy_a) busy_ok = 0;
      if (disturb && k == 2) begin
        start_a = 1'b1; pattern_a = 4'b0001; expected_a = 4'b0000; mask_a = 4'hF;
      end
      if (disturb && k == 3) start_a = 1'b0;
      if (do_reset && k == 9) begin
        check("pre_reset_rsp_nonzero", 32'(response_a != 0), 1);
        reset = 1'b0;
        #1;
        check("rst_se", se_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rsp", response_a, 0);
        check("rst_pass", pass_a, 0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0]  rsp, pat, ex, msk, mrsp;
    logic        ps;
    int          lat;
    logic [31:0] tr;
    bit          bok;
    reset = 1'b0; start_a = 0; pattern_a = 0; expected_a = 0; mask_a = 0;
    start_b = 0; pattern_b = 0; expected_b = 0; mask_b = 0;
    repeat (2) @(negedge clk);
    check("reset_se", se_a, 0);
    check("reset_scan_in", si_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_pass", pass_a, 0);
    check("reset_rsp", response_a, 0);
    reset = 1'b1;

    run_a(4'b1010, 4'b1011, 4'hF, 0, 0, rsp, ps, lat, tr, bok);
    check("basic_rsp", rsp, 4'b1011);
    check("basic_pass", ps, 1);
    check("basic_latency", lat, 10);
    check("basic_se_trace", tr, se_model(4, 1));
    check("basic_busy", bok, 1);
    @(negedge clk);
    check("done_one_cycle", done_a, 0);
    check("pass_held", pass_a, 1);
    check("rsp_held", response_a, 4'b1011);

    run_a(4'b1111, 4'b0000, 4'hF, 0, 0, rsp, ps, lat, tr, bok);
    check("wrap_rsp", rsp, 4'b0000);
    check("wrap_pass", ps, 1);

    run_a(4'b1010, 4'b0000, 4'hF, 0, 0, rsp, ps, lat, tr, bok);
    check("mismatch_rsp", rsp, 4'b1011);
    check("mismatch_pass", ps, 0);
    run_a(4'b1010, 4'b0000, 4'b0100, 0, 0, rsp, ps, lat, tr, bok);
    check("masked_pass", ps, 1);

    run_a(4'b1010, 4'b1011, 4'hF, 1, 0, rsp, ps, lat, tr, bok);
    check("busy_start_rsp", rsp, 4'b1011);
    check("busy_start_pass", ps, 1);
    check("busy_start_busy", bok, 1);
    check("busy_start_lat", lat, 10);
    @(negedge clk);
    check("no_queued_start", busy_a, 0);

    run_a(4'b1010, 4'b1011, 4'hF, 0, 1, rsp, ps, lat, tr, bok);
    run_a(4'b0011, 4'b0100, 4'hF, 0, 0, rsp, ps, lat, tr, bok);
    check("post_reset_rsp", rsp, 4'b0100);
    check("post_reset_pass", ps, 1);
    check("post_reset_lat", lat, 10);

    for (int i = 0; i < 12; i++) begin
      pat  = 4'($urandom);
      mrsp = pat + 4'd1;
      ex   = $urandom_range(0, 1) ? mrsp : 4'($urandom);
      msk  = 4'($urandom);
      run_a(pat, ex, msk, 0, 0, rsp, ps, lat, tr, bok);
      check("rand_rsp", rsp, mrsp);
      check("rand_pass", ps, 32'(((mrsp ^ ex) & msk) == 0));
      check("rand_lat", lat, 10);
    end

    tr = '0; lat = 0;
    @(negedge clk);
    pattern_b = 1'b0; expected_b = 1'b1; mask_b = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tr[k] = se_b;
      if (done_b) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("len1_lat", lat, 6);
    check("len1_se_trace", tr, se_model(1, 3));
    check("len1_rsp", response_b, 1);
    check("len1_pass", pass_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
